rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the single register-file write port between the in-order pipeline's writeback stage and a multi-cycle execution unit (divider/multiplier class) that returns results out of band. Keeps a per-register scoreboard of destinations owned by in-flight multi-cycle ops and raises a decode stall on any RAW/WAW hit. Sits between the W stage, the multi-cycle unit's result handshake, and the `reg_file` write inputs (`write_enable`, `a3`, `wd3`) of the decode stage.

## Interface
- `DATA_WIDTH`, 32, result width
- `FIFO_DEPTH`, 2, multi-cycle result buffer entries (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pl_reg_write_w`  in  1  W-stage write request
- `pl_rd_w`  in  5  W-stage destination
- `pl_result_w`  in  DATA_WIDTH  W-stage write data
- `mc_issue_d`  in  1  decode issues a multi-cycle op this cycle (only when `stall_d`=0)
- `mc_rd_d`  in  5  destination of that op
- `mc_valid`  in  1  multi-cycle result valid
- `mc_rd`  in  5  result destination
- `mc_result`  in  DATA_WIDTH  result data
- `mc_ready`  out  1  result accepted when `mc_valid & mc_ready`
- `rs1_d`, `rs2_d`, `rd_d`  in  5 each  decode-stage register fields
- `stall_d`  out  1  scoreboard hazard, hold F/D
- `reg_write_w`  out  1  to `reg_file` write_enable
- `rd_w`  out  5  to `reg_file` a3
- `result_w`  out  DATA_WIDTH  to `reg_file` wd3
- `wb_src_w`  out  2  winner: 0 none, 1 pipeline, 2 multi-cycle
- `busy`  out  1  any pending scoreboard bit or non-empty FIFO

## Operation
- Scoreboard: 32-bit `pending`, bit 0 hard-wired 0. Set bit `mc_rd_d` on `mc_issue_d` (ignored for x0). Clear bit `rd_w` when `wb_src_w`=2. Same-cycle set and clear of same bit: set wins.
- `stall_d` = `pending[rs1_d] | pending[rs2_d] | pending[rd_d]`, combinational from registered state; x0 never stalls.
- FIFO: push on `mc_valid & mc_ready`; `mc_ready` = `~full`. Results with `mc_rd`=0 are accepted and dropped (no push).
- Arbitration, fixed priority, W stage cannot be stalled:
  - `pl_reg_write_w` and `pl_rd_w`≠0 → pipeline drives port, `wb_src_w`=1.
  - else FIFO non-empty → pop head, `wb_src_w`=2.
  - else `reg_write_w`=0, `wb_src_w`=0, `rd_w`/`result_w` = 0.
- W-stage write to x0 counts as no request; FIFO may drain that cycle.
- Push and pop same cycle when not full: count unchanged, both happen. Full: no push even if a pop occurs (no pass-through).
- Pointers wrap modulo `FIFO_DEPTH`; count width `$clog2(FIFO_DEPTH+1)`.
- No bypass from `mc_result` to the write port.

## Timing
- Reset (rst_n low, asynchronous): `pending`=0, FIFO empty, pointers 0. Outputs gated by `rst_n`: `reg_write_w`=0, `wb_src_w`=0, `rd_w`=0, `result_w`=0, `mc_ready`=0, `stall_d`=0, `busy`=0.
- First cycle after release: `mc_ready`=1.
- Result accepted in cycle N → earliest write cycle N+1; deferred one cycle per W-stage write.
- Scoreboard set by issue in cycle N → `stall_d` visible cycle N+1; cleared by write in cycle N → `stall_d` drops cycle N+1 (decode reads new value via `reg_file` write-then-read).
- Reset mid-operation discards FIFO and scoreboard; the multi-cycle unit shares `rst_n`.

## Structure
- Shared package `rf_pkg`: `REG_ADDR_W`=5, `NUM_REGS`=32, `REG_X0`=0, `wb_src` constants `WB_SRC_NONE/PL/MC`.
- One sub-module: `wb_fifo` (synchronous FIFO, `DATA_WIDTH+5` wide, `FIFO_DEPTH` deep, full/empty/count).

## Test plan
- Issue `mc_rd_d`=5; next cycle `rs1_d`=5 → `stall_d`=1; `mc_valid` rd=5 data 0xDEADBEEF with W idle → write cycle+1 `rd_w`=5, `wb_src_w`=2; `stall_d`=0 next cycle.
- W writes x3 every cycle for 4 cycles while two mc results (x7, x8) arrive → both buffered, `mc_ready`=0 after second; written x7 then x8 in first two idle cycles.
- W writes x0 while FIFO holds x9 → x9 written that cycle, `wb_src_w`=2.
- Clear of x4 and new issue to x4 same cycle → `pending[4]` stays 1, `stall_d`=1 for `rd_d`=4.
- `mc_valid` with `mc_rd`=0 → accepted, no write, `busy` unchanged.
- Assert `rst_n` low with FIFO full and 3 pending bits → all outputs 0 immediately; after release `mc_ready`=1, `busy`=0, no write issued.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
// Imported by the arbiter top and anything that decodes register addresses.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    localparam logic [1:0] WB_SRC_NONE = 2'd0;
    localparam logic [1:0] WB_SRC_PL   = 2'd1;
    localparam logic [1:0] WB_SRC_MC   = 2'd2;

    // One-hot register mask; x0 always maps to an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (addr != REG_X0) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering multi-cycle results until the write port is free.
// Push when full and pop when empty are ignored; no pass-through.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the W stage and a multi-cycle unit,
// and tracks destinations of in-flight multi-cycle ops to stall decode on hazards.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pl_reg_write_w,
    input  logic [4:0]            pl_rd_w,
    input  logic [DATA_WIDTH-1:0] pl_result_w,
    input  logic                  mc_issue_d,
    input  logic [4:0]            mc_rd_d,
    input  logic                  mc_valid,
    input  logic [4:0]            mc_rd,
    input  logic [DATA_WIDTH-1:0] mc_result,
    output logic                  mc_ready,
    input  logic [4:0]            rs1_d,
    input  logic [4:0]            rs2_d,
    input  logic [4:0]            rd_d,
    output logic                  stall_d,
    output logic                  reg_write_w,
    output logic [4:0]            rd_w,
    output logic [DATA_WIDTH-1:0] result_w,
    output logic [1:0]            wb_src_w,
    output logic                  busy
);

    localparam int unsigned EntryW = DATA_WIDTH + REG_ADDR_W;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0]     fifo_wdata, fifo_rdata;
    logic [CntW-1:0]       fifo_count;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pl_req;

    assign pl_req     = pl_reg_write_w & (pl_rd_w != REG_X0);
    // Results aimed at x0 are accepted by the handshake but never stored.
    assign fifo_push  = mc_valid & ~fifo_full & (mc_rd != REG_X0);
    assign fifo_pop   = ~pl_req & ~fifo_empty;
    assign fifo_wdata = {mc_rd, mc_result};
    assign head_rd    = fifo_rdata[DATA_WIDTH +: REG_ADDR_W];
    assign head_data  = fifo_rdata[DATA_WIDTH-1:0];

    wb_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Set applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d = pending_d & ~reg_mask(head_rd);
        end
        if (mc_issue_d) begin
            pending_d = pending_d | reg_mask(mc_rd_d);
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        reg_write_w = 1'b0;
        rd_w        = '0;
        result_w    = '0;
        wb_src_w    = WB_SRC_NONE;
        if (rst_n) begin
            if (pl_req) begin
                reg_write_w = 1'b1;
                rd_w        = pl_rd_w;
                result_w    = pl_result_w;
                wb_src_w    = WB_SRC_PL;
            end else if (!fifo_empty) begin
                reg_write_w = 1'b1;
                rd_w        = head_rd;
                result_w    = head_data;
                wb_src_w    = WB_SRC_MC;
            end
        end
    end

    assign mc_ready = rst_n & ~fifo_full;
    assign stall_d  = rst_n & (pending_q[rs1_d] | pending_q[rs2_d] | pending_q[rd_d]);
    assign busy     = rst_n & ((|pending_q) | (fifo_count != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus queues expected writes, a negedge
// monitor pops and compares every write the DUT presents.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pl_reg_write_w;
    logic [4:0]  pl_rd_w;
    logic [31:0] pl_result_w;
    logic        mc_issue_d;
    logic [4:0]  mc_rd_d;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_result;
    logic        mc_ready;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        stall_d;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [1:0]  wb_src_w;
    logic        busy;

    typedef struct packed {
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pl_reg_write_w (pl_reg_write_w),
        .pl_rd_w        (pl_rd_w),
        .pl_result_w    (pl_result_w),
        .mc_issue_d     (mc_issue_d),
        .mc_rd_d        (mc_rd_d),
        .mc_valid       (mc_valid),
        .mc_rd          (mc_rd),
        .mc_result      (mc_result),
        .mc_ready       (mc_ready),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rd_d           (rd_d),
        .stall_d        (stall_d),
        .reg_write_w    (reg_write_w),
        .rd_w           (rd_w),
        .result_w       (result_w),
        .wb_src_w       (wb_src_w),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic idle();
        pl_reg_write_w = 1'b0; pl_rd_w = '0; pl_result_w = '0;
        mc_issue_d = 1'b0; mc_rd_d = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_result = '0;
        rs1_d = '0; rs2_d = '0; rd_d = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.src = src; e.rd = rd; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pl_write(input logic [4:0] rd, input logic [31:0] d);
        pl_reg_write_w = 1'b1; pl_rd_w = rd; pl_result_w = d;
    endtask

    task automatic mc_send(input logic [4:0] rd, input logic [31:0] d);
        mc_valid = 1'b1; mc_rd = rd; mc_result = d;
    endtask

    // Monitor: every presented write must match the head of the expectation queue.
    always @(negedge clk) begin
        wr_t e;
        if (reg_write_w !== 1'b0 || wb_src_w !== 2'd0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got src=%0d rd=%0d data=0x%0h, required no write",
                         wb_src_w, rd_w, result_w);
            end else begin
                e = exp_q.pop_front();
                chk("wr_enable", {31'd0, reg_write_w}, 32'd1);
                chk("wr_src", {30'd0, wb_src_w}, {30'd0, e.src});
                chk("wr_rd", {27'd0, rd_w}, {27'd0, e.rd});
                chk("wr_data", result_w, e.data);
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_reg_write", {31'd0, reg_write_w}, 32'd0);
        chk("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
        chk("rst_stall", {31'd0, stall_d}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Issue to x5, hazard on rs1, result drains through the FIFO.
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd5;
        @(negedge clk); chk("stall_before_set", {31'd0, stall_d}, 32'd0);
        tick(); idle(); rs1_d = 5'd5;
        @(negedge clk); chk("stall_rs1_x5", {31'd0, stall_d}, 32'd1);
        chk("busy_pending", {31'd0, busy}, 32'd1);
        tick(); idle(); rs1_d = 5'd5; mc_send(5'd5, 32'hDEADBEEF);
        @(negedge clk); chk("mc_ready_empty", {31'd0, mc_ready}, 32'd1);
        tick(); idle(); rs1_d = 5'd5; expect_wr(2'd2, 5'd5, 32'hDEADBEEF);
        @(negedge clk); chk("stall_during_write", {31'd0, stall_d}, 32'd1);
        tick(); idle(); rs1_d = 5'd5;
        @(negedge clk); chk("stall_cleared", {31'd0, stall_d}, 32'd0);
        chk("busy_cleared", {31'd0, busy}, 32'd0);

        // W stage holds the port for four cycles while x7 and x8 fill the FIFO.
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd7;
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd8;
        for (int i = 0; i < 4; i++) begin
            tick(); idle();
            pl_write(5'd3, 32'h30 + i);
            expect_wr(2'd1, 5'd3, 32'h30 + i);
            if (i == 0) mc_send(5'd7, 32'h7777_0000);
            if (i == 1) mc_send(5'd8, 32'h8888_0000);
            @(negedge clk);
            chk("mc_ready_fill", {31'd0, mc_ready}, (i >= 2) ? 32'd0 : 32'd1);
        end
        tick(); idle(); expect_wr(2'd2, 5'd7, 32'h7777_0000);
        tick(); idle(); expect_wr(2'd2, 5'd8, 32'h8888_0000);
        @(negedge clk); chk("mc_ready_after_pop", {31'd0, mc_ready}, 32'd1);
        tick(); idle();
        @(negedge clk); chk("busy_after_drain", {31'd0, busy}, 32'd0);

        // A W-stage write to x0 is no request, so the FIFO drains x9.
        tick(); idle(); pl_write(5'd1, 32'h11); mc_send(5'd9, 32'h99);
        expect_wr(2'd1, 5'd1, 32'h11);
        tick(); idle(); pl_write(5'd0, 32'h55); expect_wr(2'd2, 5'd9, 32'h99);
        @(negedge clk); chk("x0_write_src", {30'd0, wb_src_w}, 32'd2);

        // Result to x0 is accepted and dropped.
        tick(); idle();
        @(negedge clk); chk("busy_before_x0_result", {31'd0, busy}, 32'd0);
        tick(); idle(); mc_send(5'd0, 32'hBAD);
        @(negedge clk); chk("x0_result_ready", {31'd0, mc_ready}, 32'd1);
        tick(); idle();
        @(negedge clk); chk("busy_after_x0_result", {31'd0, busy}, 32'd0);

        // Same-cycle clear and reissue of x4: the set must win.
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd4;
        tick(); idle(); mc_send(5'd4, 32'h44);
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd4; expect_wr(2'd2, 5'd4, 32'h44);
        tick(); idle(); rd_d = 5'd4;
        @(negedge clk); chk("stall_set_wins", {31'd0, stall_d}, 32'd1);

        // Fill FIFO with three pending bits, then reset mid-operation.
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd10;
        tick(); idle(); mc_issue_d = 1'b1; mc_rd_d = 5'd11;
        pl_write(5'd2, 32'h20); expect_wr(2'd1, 5'd2, 32'h20); mc_send(5'd12, 32'hC0);
        tick(); idle(); pl_write(5'd2, 32'h21); expect_wr(2'd1, 5'd2, 32'h21);
        mc_send(5'd13, 32'hD0);
        tick(); idle(); rd_d = 5'd4; pl_write(5'd2, 32'h22);
        chk("full_mc_ready", {31'd0, mc_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reg_write", {31'd0, reg_write_w}, 32'd0);
        chk("mid_rst_wb_src", {30'd0, wb_src_w}, 32'd0);
        chk("mid_rst_rd_w", {27'd0, rd_w}, 32'd0);
        chk("mid_rst_result_w", result_w, 32'd0);
        chk("mid_rst_mc_ready", {31'd0, mc_ready}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_d}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        idle(); rd_d = 5'd4;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_mc_ready", {31'd0, mc_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_stall", {31'd0, stall_d}, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
